// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source count default,
// FSM state encoding, cause width and the fixed-priority encoder.
package irq_pkg;

   localparam int N_SRC_DEF = 8;
   localparam int MAX_SRC   = 8;
   localparam int CAUSE_W   = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   // Lowest set index wins; index 0 is the highest priority.
   function automatic logic [CAUSE_W-1:0] prio_enc(input logic [MAX_SRC-1:0] vec);
      prio_enc = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (vec[i]) prio_enc = CAUSE_W'(i);
      end
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-line two-flop synchronizer followed by a delay flop for rising-edge
// detection. prev resets to 0 so a line already high at reset release
// produces exactly one edge.
module irq_sync #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic [N-1:0] hw_irq,
   output logic [N-1:0] rise
);

   logic [N-1:0] s1;
   logic [N-1:0] s2;
   logic [N-1:0] prev;

   // Synchronize the raw lines and keep one cycle of history for the edge.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= hw_irq;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign rise = s2 & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-captured pending register, CPU-written mask,
// fixed-priority selection and a non-nesting request/service handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request presented; waiting for an unmasked pending bit
// REQ     | irq_req high, cause frozen; waiting for irq_ack
// SERVICE | handler running, irq_busy high; waiting for irq_eret
module irq_controller
   import irq_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic [N_SRC-1:0]   hw_irq,
   input  logic               cfg_we,
   input  logic [N_SRC-1:0]   cfg_wdata,
   input  logic               irq_ack,
   input  logic               irq_eret,
   output logic               irq_req,
   output logic [CAUSE_W-1:0] irq_cause,
   output logic [N_SRC-1:0]   irq_pending,
   output logic [N_SRC-1:0]   irq_mask,
   output logic               irq_busy
);

   irq_state_e         state_q;
   irq_state_e         state_d;
   logic [N_SRC-1:0]   rise;
   logic [N_SRC-1:0]   pending_q;
   logic [N_SRC-1:0]   mask_q;
   logic [N_SRC-1:0]   clr_vec;
   logic [MAX_SRC-1:0] pm_ext;
   logic [CAUSE_W-1:0] cause_q;
   logic               pm_any;
   logic               ack_take;

   irq_sync #(.N(N_SRC)) u_sync (
      .clk    (clk),
      .clr_n  (clr_n),
      .hw_irq (hw_irq),
      .rise   (rise)
   );

   // Mask register; writing it never touches pending.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) mask_q <= '0;
      else if (cfg_we) mask_q <= cfg_wdata;
   end

   assign ack_take = (state_q == REQ) && irq_ack;

   // One-hot clear of the accepted cause, only on an ack that is honoured.
   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < N_SRC; i++) begin
         clr_vec[i] = ack_take && (cause_q == CAUSE_W'(i));
      end
   end

   // Pending capture; a new edge on the same bit beats the clear.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) pending_q <= '0;
      else pending_q <= (pending_q & ~clr_vec) | rise;
   end

   // Zero-extend the eligible set to the encoder's fixed width.
   always_comb begin
      pm_ext = '0;
      pm_ext[N_SRC-1:0] = pending_q & mask_q;
   end

   assign pm_any = |pm_ext;

   // State register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state_q <= IDLE;
      else state_q <= state_d;
   end

   // Next-state logic; stray ack/eret fall through to the hold default.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pm_any) state_d = REQ;
         REQ:     if (irq_ack) state_d = SERVICE;
         SERVICE: if (irq_eret) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Cause is frozen on entry to REQ so later edges or mask writes cannot move it.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) cause_q <= '0;
      else if ((state_q == IDLE) && pm_any) cause_q <= prio_enc(pm_ext);
   end

   assign irq_req     = (state_q == REQ);
   assign irq_busy    = (state_q == SERVICE);
   assign irq_cause   = cause_q;
   assign irq_pending = pending_q;
   assign irq_mask    = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a vector table for the main
// request/priority flow plus hand-built sequences for masking, re-trigger
// during service, asynchronous reset and level-held lines.
module tb_irq_controller;

   typedef struct {
      logic [7:0] hw;
      logic       we;
      logic [7:0] wd;
      logic       ack;
      logic       eret;
      logic       req;
      logic [2:0] cause;
      logic [7:0] pend;
      logic [7:0] mask;
      logic       busy;
   } vec_t;

   typedef struct {
      string      tag;
      logic       req;
      logic [2:0] cause;
      logic [7:0] pend;
      logic [7:0] mask;
      logic       busy;
   } exp_t;

   logic       clk;
   logic       clr_n;
   logic [7:0] hw_irq;
   logic       cfg_we;
   logic [7:0] cfg_wdata;
   logic       irq_ack;
   logic       irq_eret;
   logic       irq_req;
   logic [2:0] irq_cause;
   logic [7:0] irq_pending;
   logic [7:0] irq_mask;
   logic       irq_busy;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t tbl[19];

   irq_controller #(.N_SRC(8)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .hw_irq      (hw_irq),
      .cfg_we      (cfg_we),
      .cfg_wdata   (cfg_wdata),
      .irq_ack     (irq_ack),
      .irq_eret    (irq_eret),
      .irq_req     (irq_req),
      .irq_cause   (irq_cause),
      .irq_pending (irq_pending),
      .irq_mask    (irq_mask),
      .irq_busy    (irq_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic [7:0] hw, logic we, logic [7:0] wd, logic ack, logic eret,
                               logic req, logic [2:0] cause, logic [7:0] pend, logic [7:0] mask,
                               logic busy);
      vec_t r;
      r.hw = hw; r.we = we; r.wd = wd; r.ack = ack; r.eret = eret;
      r.req = req; r.cause = cause; r.pend = pend; r.mask = mask; r.busy = busy;
      return r;
   endfunction

   task automatic push_exp(string tag, vec_t x);
      exp_t e;
      e.tag = tag; e.req = x.req; e.cause = x.cause; e.pend = x.pend;
      e.mask = x.mask; e.busy = x.busy;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e = sb.pop_front();
      checks++;
      if (irq_req !== e.req || irq_cause !== e.cause || irq_pending !== e.pend ||
          irq_mask !== e.mask || irq_busy !== e.busy) begin
         errors++;
         $display("FAIL %s: got req=%b cause=%0d pend=%02h mask=%02h busy=%b, need req=%b cause=%0d pend=%02h mask=%02h busy=%b",
                  e.tag, irq_req, irq_cause, irq_pending, irq_mask, irq_busy,
                  e.req, e.cause, e.pend, e.mask, e.busy);
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
   task automatic apply(string tag, vec_t x);
      hw_irq = x.hw; cfg_we = x.we; cfg_wdata = x.wd; irq_ack = x.ack; irq_eret = x.eret;
      push_exp(tag, x);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      clr_n = 1'b0; hw_irq = '0; cfg_we = 1'b0; cfg_wdata = '0; irq_ack = 1'b0; irq_eret = 1'b0;

      // Main flow: latency, ack clearing, simultaneous sources, stray handshakes.
      tbl[0]  = mk(8'h00, 1, 8'hFF, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
      tbl[1]  = mk(8'h08, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
      tbl[2]  = mk(8'h08, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
      tbl[3]  = mk(8'h08, 0, 8'h00, 0, 0,  0, 3'd0, 8'h08, 8'hFF, 0);
      tbl[4]  = mk(8'h08, 0, 8'h00, 0, 0,  1, 3'd3, 8'h08, 8'hFF, 0);
      tbl[5]  = mk(8'h00, 0, 8'h00, 1, 0,  0, 3'd3, 8'h00, 8'hFF, 1);
      tbl[6]  = mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd3, 8'h00, 8'hFF, 1);
      tbl[7]  = mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd3, 8'h00, 8'hFF, 0);
      tbl[8]  = mk(8'h24, 0, 8'h00, 0, 0,  0, 3'd3, 8'h00, 8'hFF, 0);
      tbl[9]  = mk(8'h24, 0, 8'h00, 0, 0,  0, 3'd3, 8'h00, 8'hFF, 0);
      tbl[10] = mk(8'h24, 0, 8'h00, 0, 0,  0, 3'd3, 8'h24, 8'hFF, 0);
      tbl[11] = mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd2, 8'h24, 8'hFF, 0);
      tbl[12] = mk(8'h00, 0, 8'h00, 1, 0,  0, 3'd2, 8'h20, 8'hFF, 1);
      tbl[13] = mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd2, 8'h20, 8'hFF, 0);
      tbl[14] = mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd5, 8'h20, 8'hFF, 0);
      tbl[15] = mk(8'h00, 0, 8'h00, 1, 0,  0, 3'd5, 8'h00, 8'hFF, 1);
      tbl[16] = mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd5, 8'h00, 8'hFF, 0);
      tbl[17] = mk(8'h00, 0, 8'h00, 1, 0,  0, 3'd5, 8'h00, 8'hFF, 0);
      tbl[18] = mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd5, 8'h00, 8'hFF, 0);

      // Reset state, held across an edge.
      @(posedge clk);
      #1;
      push_exp("reset_state", mk(8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0));
      check_pop();
      clr_n = 1'b1;

      for (int i = 0; i < 19; i++) apply($sformatf("tbl%0d", i), tbl[i]);

      // Masked source stays pending, unmasking raises the request; mask drop in REQ.
      apply("mask0_wr",   mk(8'h00, 1, 8'h00, 0, 0,  0, 3'd5, 8'h00, 8'h00, 0));
      apply("mask0_p1",   mk(8'h02, 0, 8'h00, 0, 0,  0, 3'd5, 8'h00, 8'h00, 0));
      apply("mask0_p2",   mk(8'h02, 0, 8'h00, 0, 0,  0, 3'd5, 8'h00, 8'h00, 0));
      apply("mask0_p3",   mk(8'h02, 0, 8'h00, 0, 0,  0, 3'd5, 8'h02, 8'h00, 0));
      apply("mask0_p4",   mk(8'h02, 0, 8'h00, 0, 0,  0, 3'd5, 8'h02, 8'h00, 0));
      apply("mask0_hold", mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd5, 8'h02, 8'h00, 0));
      apply("unmask_wr",  mk(8'h00, 1, 8'h02, 0, 0,  0, 3'd5, 8'h02, 8'h02, 0));
      apply("unmask_req", mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd1, 8'h02, 8'h02, 0));
      apply("req_mask0",  mk(8'h00, 1, 8'h00, 0, 0,  1, 3'd1, 8'h02, 8'h00, 0));
      apply("req_ack",    mk(8'h00, 0, 8'h00, 1, 0,  0, 3'd1, 8'h00, 8'h00, 1));
      apply("req_eret",   mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd1, 8'h00, 8'h00, 0));

      // New edge on source 4 while servicing source 4.
      apply("s4_r1",      mk(8'h10, 1, 8'hFF, 0, 0,  0, 3'd1, 8'h00, 8'hFF, 0));
      apply("s4_r2",      mk(8'h10, 0, 8'h00, 0, 0,  0, 3'd1, 8'h00, 8'hFF, 0));
      apply("s4_r3",      mk(8'h10, 0, 8'h00, 0, 0,  0, 3'd1, 8'h10, 8'hFF, 0));
      apply("s4_req",     mk(8'h10, 0, 8'h00, 0, 0,  1, 3'd4, 8'h10, 8'hFF, 0));
      apply("s4_ack",     mk(8'h00, 0, 8'h00, 1, 0,  0, 3'd4, 8'h00, 8'hFF, 1));
      apply("s4_low1",    mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd4, 8'h00, 8'hFF, 1));
      apply("s4_low2",    mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd4, 8'h00, 8'hFF, 1));
      apply("s4_hi1",     mk(8'h10, 0, 8'h00, 0, 0,  0, 3'd4, 8'h00, 8'hFF, 1));
      apply("s4_hi2",     mk(8'h10, 0, 8'h00, 0, 0,  0, 3'd4, 8'h00, 8'hFF, 1));
      apply("s4_repend",  mk(8'h10, 0, 8'h00, 0, 0,  0, 3'd4, 8'h10, 8'hFF, 1));
      apply("s4_noreq",   mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd4, 8'h10, 8'hFF, 1));
      apply("s4_eret",    mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd4, 8'h10, 8'hFF, 0));
      apply("s4_reissue", mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd4, 8'h10, 8'hFF, 0));

      // Asynchronous reset in REQ, line held high through release.
      hw_irq = 8'h01;
      #2;
      clr_n = 1'b0;
      #1;
      push_exp("async_rst", mk(8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0));
      check_pop();
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      apply("rst_stray_ack", mk(8'h01, 0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 8'h00, 0));
      apply("rst_rel2",      mk(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'h00, 0));
      apply("rst_rel_edge",  mk(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 8'h01, 8'h00, 0));
      apply("rst_unmask",    mk(8'h01, 1, 8'h01, 0, 0,  0, 3'd0, 8'h01, 8'h01, 0));
      apply("rst_req",       mk(8'h01, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'h01, 0));
      apply("rst_ack",       mk(8'h01, 0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 8'h01, 1));
      apply("rst_eret",      mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd0, 8'h00, 8'h01, 0));
      for (int i = 0; i < 3; i++)
         apply($sformatf("rst_low%0d", i), mk(8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 8'h01, 0));

      // Level-held line: one request over 50 cycles.
      apply("lvl_r1",   mk(8'h01, 1, 8'hFF, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0));
      apply("lvl_r2",   mk(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0));
      apply("lvl_pend", mk(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 8'h01, 8'hFF, 0));
      apply("lvl_req",  mk(8'h01, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("lvl_ack",  mk(8'h01, 0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 8'hFF, 1));
      apply("lvl_eret", mk(8'h01, 0, 8'h00, 0, 1,  0, 3'd0, 8'h00, 8'hFF, 0));
      for (int i = 0; i < 44; i++)
         apply($sformatf("lvl_hold%0d", i), mk(8'h01, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 8'hFF, 0));
      apply("lvl_low1", mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0));
      apply("lvl_low2", mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0));

      // Ack landing on the same cycle as a fresh edge of the cause bit.
      apply("col_r1",   mk(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0));
      apply("col_r2",   mk(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0));
      apply("col_pend", mk(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_req",  mk(8'h01, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_lo1",  mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_lo2",  mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_lo3",  mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_hi1",  mk(8'h01, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_hi2",  mk(8'h01, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_ack",  mk(8'h01, 0, 8'h00, 1, 0,  0, 3'd0, 8'h01, 8'hFF, 1));
      apply("col_eret", mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_req2", mk(8'h00, 0, 8'h00, 0, 0,  1, 3'd0, 8'h01, 8'hFF, 0));
      apply("col_ack2", mk(8'h00, 0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 8'hFF, 1));
      apply("col_done", mk(8'h00, 0, 8'h00, 0, 1,  0, 3'd0, 8'h00, 8'hFF, 0));

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries left, need 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_SRC, default 8, number of hardware interrupt sources (1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 hw_irq  input  N_SRC  raw asynchronous interrupt lines, rising-edge significant.
REQ-005 cfg_we  input  1  mask write strobe from CPU.
REQ-006 cfg_wdata  input  N_SRC  new mask value; bit=1 enables source.
REQ-007 irq_ack  input  1  CPU accepts the presented interrupt.
REQ-008 irq_eret  input  1  CPU returned from handler.
REQ-009 irq_req  output  1  interrupt request to CPU.
REQ-010 irq_cause  output  3  index of the presented source.
REQ-011 irq_pending  output  N_SRC  pending register, unmasked view.
REQ-012 irq_mask  output  N_SRC  current mask register.
REQ-013 irq_busy  output  1  high while in SERVICE.

Function
REQ-014 Each hw_irq bit SHALL pass a 2-flop synchronizer (s1, s2) plus a delay flop (prev); edge = s2 & ~prev.
REQ-015 pending SHALL update as pending <= (pending & ~clr_vec) | edge each cycle; set wins over clear on the same bit.
REQ-016 Mask SHALL load cfg_wdata on cfg_we; masking SHALL NOT clear pending bits.
REQ-017 FSM states: IDLE, REQ, SERVICE.
REQ-018 IDLE -> REQ when (pending & mask) != 0; cause latched = lowest set index of (pending & mask) (index 0 highest priority).
REQ-019 REQ: irq_req=1, irq_cause held stable; mask writes or new edges SHALL NOT change cause.
REQ-020 REQ -> SERVICE on irq_ack; clr_vec = one-hot(cause) that cycle; irq_req deasserts the cycle after ack.
REQ-021 SERVICE: irq_req=0, irq_busy=1; SERVICE -> IDLE on irq_eret; no nesting.
REQ-022 irq_ack outside REQ and irq_eret outside SERVICE SHALL be ignored.
REQ-023 Latency: hw_irq high before rising edge k, source unmasked, FSM IDLE -> pending set after edge k+2, irq_req high after edge k+3.
REQ-024 Re-issue: from IDLE after eret, next request appears 1 cycle later if any pending&mask remains.
REQ-025 Level-held hw_irq SHALL produce exactly one pending set; a new edge needs low then high (each held >=2 cycles).
REQ-026 If cause bit is cleared by mask in REQ, request SHALL still complete normally.
REQ-027 irq_cause upper bits SHALL be 0 when N_SRC < 8.

Reset
REQ-028 clr_n low SHALL immediately force: state IDLE, irq_req 0, irq_cause 0, irq_busy 0, pending 0, mask 0, s1/s2/prev 0.
REQ-029 Reset mid-REQ or mid-SERVICE SHALL abandon the request with no ack required.
REQ-030 Lines already high at reset release SHALL register as one edge (prev resets to 0).

Structure
REQ-031 Package irq_pkg SHALL hold N_SRC default, state enum (IDLE/REQ/SERVICE), cause width constant.
REQ-032 Sub-module irq_sync SHALL implement per-bit synchronizer and edge detect, instantiated once, N_SRC wide.
REQ-033 Priority encode and FSM SHALL live in irq_controller; no combinational path from hw_irq to any output.

Verification
REQ-034 Mask=0xFF, pulse hw_irq[3] 4 cycles -> irq_req at edge k+3, irq_cause=3; ack -> pending[3]=0, busy=1.
REQ-035 hw_irq[5] and [2] rise same cycle, mask=0xFF -> cause=2 first; after ack+eret -> cause=5 next cycle.
REQ-036 Mask=0x00, pulse hw_irq[1] -> pending=0x02, no irq_req; write mask=0x02 -> irq_req 1 cycle later, cause=1.
REQ-037 In SERVICE for source 4, new hw_irq[4] edge -> pending[4]=1, no irq_req until eret, then cause=4.
REQ-038 Assert clr_n low during REQ -> irq_req, pending, mask drop to 0 asynchronously; stray ack after release ignored.
REQ-039 Hold hw_irq[0] high 50 cycles -> exactly one request; ack arriving same cycle as new edge on cause -> pending stays 1.
